pipe_register: RTL and testbench
================================

Name: pipe_register

Overview:
- Parametrised successor to the single `register` block.
- Elastic, DEPTH-stage pipeline register carrying NCH signed lanes of WIDTH bits each, e.g. CORDIC x/y/z, between iteration stages.
- Adds a valid/ready handshake with backpressure, bubble collapsing, a synchronous flush and an occupancy count.
- Sits between CORDIC micro-rotation stages and at the core's input/output boundary.

Parameters:
- WIDTH, 32: bits per lane, signed two's complement.
- NCH, 3: number of lanes packed per word (lane 0 in bits [WIDTH-1:0]).
- DEPTH, 4: number of register stages; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all stage valids.
- in_valid  in  1  upstream word present.
- in_ready  out  1  pipeline accepts a word this cycle.
- in_data  in  NCH*WIDTH  packed lanes, signed.
- out_valid  out  1  word present at the last stage.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  NCH*WIDTH  last-stage data.
- count  out  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset (async, immediate on rst rise, held while rst=1):
  - all stage valids=0, all stage data=0, count=0.
  - out_valid=0, out_data=0, in_ready=1 once rst deasserts.
- Stage i state: v[i], d[i]; stage DEPTH-1 drives out_valid/out_data.
- Ready chain (combinational, bubble collapsing):
  - rdy[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - rdy[i] = !v[i] | rdy[i+1].
  - in_ready = rdy[0] & !flush.
- Per-stage update at each clk edge, when rdy[i]=1:
  - v[i] <= v[i-1] (stage 0 takes in_valid & in_ready).
  - d[i] <= d[i-1] (stage 0 takes in_data), only when the incoming valid is 1.
  - Data is not loaded from bubbles; d[i] otherwise holds.
- When rdy[i]=0, stage i holds both v[i] and d[i].
- Transfers: in-handshake = in_valid & in_ready; out-handshake = out_valid & out_ready.
- Latency with no stalls: a word accepted in cycle c is on out_data with out_valid=1 in cycle c+DEPTH.
- Throughput is 1 word/cycle sustained.
- Ordering is strictly FIFO; no word is duplicated or dropped except by flush/reset.
- Backpressure:
  - with out_ready=0 the pipeline compacts toward the output.
  - in_ready falls only when all DEPTH stages are valid (count=DEPTH).
- Full with out_ready=1: accept and emit in the same cycle; count unchanged.
- Empty: out_valid=0; out_data holds the last loaded value (not cleared).
- count updates each edge as count + in-handshake - out-handshake, where out-handshake = out_valid & out_ready & !flush.
- Flush (priority over everything except rst):
  - in_ready=0 and out_valid=0 combinationally during the flush cycle.
  - At the next edge all v[i]=0 and count=0; data registers hold.
  - No handshake completes in a flush cycle.
- Arithmetic: none; lanes pass bit-exact, with no sign extension or truncation.
- DEPTH=1: a single load-enabled register with handshake and simultaneous accept/emit.
- rst asserted mid-stream discards all in-flight words asynchronously.

Decomposition:
- Shared package cordic_pkg:
  - WIDTH default constant and lane index helper (lane k = [k*WIDTH +: WIDTH]).
  - count-width function clog2.
- One natural sub-module, pipe_stage: a single valid+data stage with rdy_in/rdy_out, flush and async rst.
- pipe_register instantiates DEPTH pipe_stage instances in a generate loop and adds the counter.

Test Plan (WIDTH=32, NCH=3, DEPTH=4 unless stated):
1. Reset: rst=1 with in_valid=1, in_data lanes = 32'h88888888 -> out_valid=0, out_data=0, count=0 while rst=1; in_ready=1 after release.
2. Streaming: out_ready=1, push lanes {1,2,3},{4,5,6},{7,8,9} in cycles 0,1,2 -> out_valid=1 in cycles 4,5,6 with the same values in order; count peaks at 3.
3. Backpressure:
   - Stimulus: out_ready=0; push 6 words, lane0 = 10..15.
   - Fill: in_ready=0 after 4 accepts, count=4, out_data lane0=10.
   - Drain: set out_ready=1 -> outputs 10,11,12,13, then 14,15 once they are accepted, with no gaps or duplicates.
4. Bubble collapse: push 32'hF8888888 in cycle 0, idle, push 32'hFF888888 in cycle 2, out_ready=0 -> both compact to stages 3 and 2 by cycle 5, count=2; releasing out_ready emits them back-to-back.
5. Flush:
   - Stimulus: count=3; assert flush=1 for one cycle with in_valid=1, in_data=32'h12345678.
   - Flush cycle: in_ready=0, out_valid=0.
   - Next cycle: count=0, out_valid=0; 32'h12345678 is never emitted.
6. Async reset mid-operation:
   - Stimulus: count=4; raise rst between clock edges.
   - Response: out_valid=0 and count=0 before the next edge; after release the pipeline accepts normally.
   - DEPTH=1 run: a word pushed in cycle c appears in cycle c+1, with simultaneous accept/emit at full.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: definitions shared by the CORDIC pipeline blocks.
//   WIDTH_DEF  default lane width in bits (signed two's complement)
//   lane_t     one signed lane at the default width
//   lane_lsb   bit offset of lane k in a packed word (lane k = [k*w +: w])
//   clog2      ceiling log2, used to size the occupancy counter
package cordic_pkg;

    localparam int WIDTH_DEF = 32;

    typedef logic signed [WIDTH_DEF-1:0] lane_t;

    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

    // Number of bits needed to index n distinct values (n >= 1).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one elastic valid+data register stage.
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   flush          synchronous clear of the valid bit (data holds)
//   valid_in       valid of the word offered by the upstream stage
//   data_in        data of the word offered by the upstream stage
//   rdy_in         downstream stage (or consumer) can take our word
//   rdy_out        this stage can take a word this cycle
//   valid_out      this stage holds a word
//   data_out       data held by this stage
module pipe_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         valid_in,
    input  logic [W-1:0] data_in,
    input  logic         rdy_in,
    output logic         rdy_out,
    output logic         valid_out,
    output logic [W-1:0] data_out
);

    logic         v_q;
    logic         v_d;
    logic [W-1:0] d_q;
    logic [W-1:0] d_d;

    // An empty stage is always ready, so bubbles are squeezed out even
    // while the consumer stalls.
    assign rdy_out = !v_q | rdy_in;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (rdy_out) begin
            v_d = valid_in;
            // Bubbles never overwrite data, so an emptied stage keeps its
            // last word visible.
            if (valid_in) begin
                d_d = data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign valid_out = v_q;
    assign data_out  = d_q;

endmodule

// File: rtl/pipe_register.sv
// pipe_register: elastic DEPTH-stage pipeline register for NCH signed lanes.
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   flush       synchronous clear of every stage valid and the count
//   in_valid    upstream word present
//   in_ready    pipeline accepts a word this cycle
//   in_data     packed lanes, lane 0 in the low WIDTH bits
//   out_valid   word present at the last stage
//   out_ready   downstream accepts this cycle
//   out_data    last-stage data (holds its last value when empty)
//   count       number of valid stages
// DEPTH must lie in 1..16.
module pipe_register
    import cordic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NCH   = 3,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NCH*WIDTH-1:0]         in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NCH*WIDTH-1:0]         out_data,
    output logic [clog2(DEPTH+1)-1:0]    count
);

    localparam int DW = NCH * WIDTH;
    localparam int CW = clog2(DEPTH + 1);

    logic          v_w [DEPTH];
    logic [DW-1:0] d_w [DEPTH];

    logic          in_hs;
    logic          out_hs;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Each stage keeps its own ready net; the chain runs from the output
    // back to the input through these per-block signals.
    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            logic          rdy;
            logic          rdy_dn;
            logic          vin;
            logic [DW-1:0] din;

            if (i == 0) begin : g_head
                assign vin = in_valid & in_ready;
                assign din = in_data;
            end else begin : g_body
                assign vin = v_w[i-1];
                assign din = d_w[i-1];
            end

            if (i == DEPTH - 1) begin : g_tail
                assign rdy_dn = out_ready;
            end else begin : g_link
                assign rdy_dn = g_stage[i+1].rdy;
            end

            pipe_stage #(
                .W(DW)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .valid_in (vin),
                .data_in  (din),
                .rdy_in   (rdy_dn),
                .rdy_out  (rdy),
                .valid_out(v_w[i]),
                .data_out (d_w[i])
            );
        end
    endgenerate

    assign in_ready  = g_stage[0].rdy & !flush;
    // Masking with flush guarantees no output handshake in a flush cycle.
    assign out_valid = v_w[DEPTH-1] & !flush;

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_lane
            assign out_data[lane_lsb(k, WIDTH) +: WIDTH] = d_w[DEPTH-1][lane_lsb(k, WIDTH) +: WIDTH];
        end
    endgenerate

    always_comb begin
        in_hs   = in_valid & in_ready;
        out_hs  = out_valid & out_ready;
        count_d = count_q + CW'(in_hs) - CW'(out_hs);
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_pipe_register.sv
module tb_pipe_register;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
    logic [2:0]  count;

    logic        d1_in_valid;
    logic        d1_in_ready;
    logic [95:0] d1_in_data;
    logic        d1_out_valid;
    logic        d1_out_ready;
    logic [95:0] d1_out_data;
    logic [0:0]  d1_count;

    int vecs = 0;
    int miss = 0;

    pipe_register #(.WIDTH(32), .NCH(3), .DEPTH(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    pipe_register #(.WIDTH(32), .NCH(3), .DEPTH(1)) u_d1 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (d1_in_valid),
        .in_ready (d1_in_ready),
        .in_data  (d1_in_data),
        .out_valid(d1_out_valid),
        .out_ready(d1_out_ready),
        .out_data (d1_out_data),
        .count    (d1_count)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vecs++;
        if (obs !== exp) begin
            miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return {c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [95:0] wa;
    logic [95:0] wb;

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b1;
        in_data      = mk(32'h88888888, 32'h88888888, 32'h88888888);
        out_ready    = 1'b0;
        d1_in_valid  = 1'b0;
        d1_in_data   = '0;
        d1_out_ready = 1'b0;

        // Reset held with a word offered
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 96'h0);
        check("rst_count", count, 3'd0);
        check("rst_d1_out_valid", d1_out_valid, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Streaming, no stalls
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = mk(32'd1, 32'd2, 32'd3);
        #1;
        check("stream_in_ready", in_ready, 1'b1);
        tick();
        in_data = mk(32'd4, 32'd5, 32'd6);
        tick();
        in_data = mk(32'd7, 32'd8, 32'd9);
        tick();
        in_valid = 1'b0;
        #1;
        check("stream_c3_count", count, 3'd3);
        check("stream_c3_out_valid", out_valid, 1'b0);
        tick();
        check("stream_c4_out_valid", out_valid, 1'b1);
        check("stream_c4_out_data", out_data, mk(32'd1, 32'd2, 32'd3));
        check("stream_c4_count", count, 3'd3);
        tick();
        check("stream_c5_out_data", out_data, mk(32'd4, 32'd5, 32'd6));
        check("stream_c5_count", count, 3'd2);
        tick();
        check("stream_c6_out_valid", out_valid, 1'b1);
        check("stream_c6_out_data", out_data, mk(32'd7, 32'd8, 32'd9));
        tick();
        check("stream_c7_out_valid", out_valid, 1'b0);
        check("stream_c7_count", count, 3'd0);

        // Backpressure: fill with out_ready low, then drain
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = mk(32'(10 + k), 32'(100 + k), 32'hFFFFFFF0 + 32'(k));
            tick();
        end
        in_data = mk(32'd14, 32'd104, 32'hFFFFFFF4);
        #1;
        check("bp_full_in_ready", in_ready, 1'b0);
        check("bp_full_count", count, 3'd4);
        check("bp_full_out_valid", out_valid, 1'b1);
        check("bp_full_lane0", out_data[31:0], 32'd10);
        tick();
        check("bp_hold_in_ready", in_ready, 1'b0);
        check("bp_hold_count", count, 3'd4);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1'b1);
        for (int j = 0; j < 6; j++) begin
            if (j == 0) begin
                in_valid = 1'b1;
                in_data  = mk(32'd14, 32'd104, 32'hFFFFFFF4);
            end else if (j == 1) begin
                in_valid = 1'b1;
                in_data  = mk(32'd15, 32'd105, 32'hFFFFFFF5);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("bp_drain_out_valid", out_valid, 1'b1);
            check("bp_drain_out_data", out_data, mk(32'(10 + j), 32'(100 + j), 32'hFFFFFFF0 + 32'(j)));
            if (j == 2) begin
                check("bp_drain_count", count, 3'd4);
            end
            tick();
        end
        check("bp_empty_out_valid", out_valid, 1'b0);
        check("bp_empty_count", count, 3'd0);

        // Bubble collapse
        wa = mk(32'hF8888888, 32'hF8888888, 32'hF8888888);
        wb = mk(32'hFF888888, 32'hFF888888, 32'hFF888888);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = wa;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = wb;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("bubble_count", count, 3'd2);
        check("bubble_out_valid", out_valid, 1'b1);
        check("bubble_out_data", out_data, wa);
        check("bubble_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        tick();
        check("bubble_second_valid", out_valid, 1'b1);
        check("bubble_second_data", out_data, wb);
        tick();
        check("bubble_empty_valid", out_valid, 1'b0);
        check("bubble_empty_holds_data", out_data, wb);
        check("bubble_empty_count", count, 3'd0);

        // Flush with three words in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = mk(32'(21 + k), 32'd0, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("flush_pre_count", count, 3'd3);
        check("flush_pre_out_valid", out_valid, 1'b1);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = mk(32'h12345678, 32'h12345678, 32'h12345678);
        out_ready = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        check("flush_out_valid", out_valid, 1'b0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_after_count", count, 3'd0);
        check("flush_after_out_valid", out_valid, 1'b0);
        check("flush_data_holds", out_data, mk(32'd21, 32'd0, 32'd0));
        for (int k = 0; k < 5; k++) begin
            tick();
            check("flush_never_emitted", out_valid, 1'b0);
        end

        // Asynchronous reset while full
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = mk(32'(31 + k), 32'd7, 32'd7);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("arst_pre_count", count, 3'd4);
        check("arst_pre_out_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_count", count, 3'd0);
        check("arst_out_data", out_data, 96'h0);
        #1;
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = mk(32'd35, 32'hFFFFFFFF, 32'h80000000);
        #1;
        check("arst_post_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("arst_post_out_valid", out_valid, 1'b1);
        check("arst_post_out_data", out_data, mk(32'd35, 32'hFFFFFFFF, 32'h80000000));
        tick();
        check("arst_post_empty", out_valid, 1'b0);

        // DEPTH=1 instance
        d1_out_ready = 1'b1;
        d1_in_valid  = 1'b1;
        d1_in_data   = mk(32'hA1, 32'hA2, 32'hA3);
        #1;
        check("d1_c0_in_ready", d1_in_ready, 1'b1);
        check("d1_c0_out_valid", d1_out_valid, 1'b0);
        tick();
        d1_in_data = mk(32'hB1, 32'hB2, 32'hB3);
        #1;
        check("d1_c1_out_valid", d1_out_valid, 1'b1);
        check("d1_c1_out_data", d1_out_data, mk(32'hA1, 32'hA2, 32'hA3));
        check("d1_c1_in_ready", d1_in_ready, 1'b1);
        check("d1_c1_count", d1_count, 1'b1);
        tick();
        d1_in_data   = mk(32'hC1, 32'hC2, 32'hC3);
        d1_out_ready = 1'b0;
        #1;
        check("d1_c2_out_data", d1_out_data, mk(32'hB1, 32'hB2, 32'hB3));
        check("d1_c2_count", d1_count, 1'b1);
        check("d1_c2_in_ready", d1_in_ready, 1'b0);
        tick();
        check("d1_c3_hold_data", d1_out_data, mk(32'hB1, 32'hB2, 32'hB3));
        d1_out_ready = 1'b1;
        #1;
        check("d1_c3_in_ready", d1_in_ready, 1'b1);
        tick();
        d1_in_valid = 1'b0;
        #1;
        check("d1_c4_out_data", d1_out_data, mk(32'hC1, 32'hC2, 32'hC3));
        tick();
        check("d1_c5_out_valid", d1_out_valid, 1'b0);
        check("d1_c5_count", d1_count, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
